// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: RISC-V load/store funct3 codes and responder FSM states shared by dmem_responder and mem_lane_align
package rv_mem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: core<->memory load/store bus; master=core MEM stage (req_*, rsp_ready out), slave=responder (req_ready, rsp_* out)
interface dmem_responder_if;
  logic req_valid;
  logic req_ready;
  logic req_we;
  logic [2:0] req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic rsp_valid;
  logic rsp_ready;
  logic [31:0] rsp_rdata;
  logic rsp_err;
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: funct3/addr[1:0] lane logic; in we/funct3/addr/word/wdata, out aligned load rdata, byte enables be, replicated wdata_rep, funct3/alignment err
module mem_lane_align
  import rv_mem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        err
);
  logic [7:0] b;
  logic [15:0] h;
  logic bad_f3;
  logic misal;
  always_comb begin
    b = word[{addr, 3'b000} +: 8];
    h = addr[1] ? word[31:16] : word[15:0];
    bad_f3 = we ? (funct3[2] || funct3 == 3'b011) : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
    misal = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr != 2'b00);
    err = bad_f3 || misal;
    rdata = funct3 == F3_B  ? {{24{b[7]}}, b} :
            funct3 == F3_BU ? {24'b0, b} :
            funct3 == F3_H  ? {{16{h[15]}}, h} :
            funct3 == F3_HU ? {16'b0, h} : word;
    be = funct3[1:0] == 2'b00 ? 4'b0001 << addr :
         funct3[1:0] == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_rep = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
                funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with LATENCY wait states and internal RAM; ports clk1, rst (async active-low), bus (slave modport)
module dmem_responder
  import rv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY = 2
) (
  input logic clk1,
  input logic rst,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_t state;
  logic [2:0] cnt;
  logic we_q;
  logic [2:0] f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic err_q;
  logic [31:0] mem [DEPTH_WORDS];
  logic idle;
  logic we_c;
  logic [2:0] f3_c;
  logic [31:0] addr_c;
  logic [31:0] wdata_c;
  logic [AW-1:0] idx;
  logic [31:0] word;
  logic [31:0] ld;
  logic [31:0] wrep;
  logic [3:0] be;
  logic al_err;
  logic oor;
  logic err;
  logic commit;
  assign idle = state == IDLE;
  always_comb begin
    we_c = idle ? bus.req_we : we_q;
    f3_c = idle ? bus.req_funct3 : f3_q;
    addr_c = idle ? bus.req_addr : addr_q;
    wdata_c = idle ? bus.req_wdata : wdata_q;
    idx = addr_c[AW+1:2];
    word = mem[idx];
    oor = {2'b00, addr_c[31:2]} >= 32'(DEPTH_WORDS);
    err = al_err || oor;
    commit = rst && ((idle && bus.req_valid && LATENCY == 0) || (state == WAIT && cnt == 3'd0));
  end
  mem_lane_align u_align (
    .we(we_c),
    .funct3(f3_c),
    .addr(addr_c[1:0]),
    .word(word),
    .wdata(wdata_c),
    .rdata(ld),
    .be(be),
    .wdata_rep(wrep),
    .err(al_err)
  );
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      we_q <= 1'b0;
      f3_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (idle && bus.req_valid) begin
        we_q <= bus.req_we;
        f3_q <= bus.req_funct3;
        addr_q <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        cnt <= 3'(LATENCY);
        state <= LATENCY == 0 ? RESP : WAIT;
      end
      if (state == WAIT && cnt != 3'd0) cnt <= cnt - 3'd1;
      if (commit) begin
        state <= RESP;
        rdata_q <= (err || we_c) ? '0 : ld;
        err_q <= err;
      end
      if (state == RESP && bus.rsp_ready) state <= IDLE;
    end
  end
  always_ff @(posedge clk1) begin
    if (commit && we_c && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
  end
  assign bus.req_ready = idle;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err = err_q;
endmodule
